// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl
//   Lookup/allocate controller in front of a set-associative tag array.
//   Accepts one request at a time, drives the array index, compares the
//   returned per-way tags against the request tag (gated by valid bits kept
//   here), runs a fill handshake with memory on a miss, writes the victim tag
//   into the array and reports hit/miss plus the way.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_addr = {tag, index}
//   resp_valid           one-cycle response strobe; resp_hit/resp_way hold
//   tag_index, tag_rd    array index and combinational per-way tag read
//   tag_we/way/wdata     array tag write (fill only)
//   mem_req/addr/ack     fill handshake with memory
//   dbg_state            current FSM state for observation
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE, so at most one request
// is in flight. resp_valid is a strobe with no backpressure. mem_req is held
// until mem_ack is sampled high while in MISS; mem_ack is ignored elsewhere.
module cache_lookup_ctrl #(
  parameter int WIDTH      = 8,
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  localparam int SETS      = TOTAL_SIZE / WAYS,
  localparam int IDX_W     = $clog2(SETS),
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH+IDX_W-1:0] req_addr,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [WAY_W-1:0]       resp_way,
  output logic [IDX_W-1:0]       tag_index,
  input  logic [WIDTH-1:0]       tag_rd [WAYS],
  output logic                   tag_we,
  output logic [WAY_W-1:0]       tag_way,
  output logic [WIDTH-1:0]       tag_wdata,
  output logic                   mem_req,
  output logic [WIDTH+IDX_W-1:0] mem_addr,
  input  logic                   mem_ack,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_FILL   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH+IDX_W-1:0]   addr_q, addr_d;
  logic [WAY_W-1:0]         victim_q, victim_d;
  logic                     resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0]         resp_way_q, resp_way_d;
  logic [SETS-1:0]          valid_q [WAYS];
  logic [WAY_W-1:0]         ptr_q [SETS];

  logic [IDX_W-1:0]         idx_q;
  logic [WIDTH-1:0]         tag_q;
  logic                     hit_any;
  logic [WAY_W-1:0]         hit_way;
  logic                     inv_any;
  logic [WAY_W-1:0]         inv_way;
  logic [WAY_W-1:0]         victim;

  assign idx_q = addr_q[IDX_W-1:0];
  assign tag_q = addr_q[WIDTH+IDX_W-1:IDX_W];

  // Scan from the highest way down so the lowest-index match is the one
  // left standing, both for hits and for the first invalid way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_q[i][idx_q] && (tag_rd[i] == tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (!valid_q[i][idx_q]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    // Only when the set is full does the round-robin pointer pick the victim.
    victim = inv_any ? inv_way : ptr_q[idx_q];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    victim_d   = victim_q;
    resp_hit_d = resp_hit_q;
    resp_way_d = resp_way_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          resp_hit_d = 1'b1;
          resp_way_d = hit_way;
          state_d    = S_RESP;
        end else begin
          victim_d = victim;
          state_d  = S_MISS;
        end
      end
      S_MISS: begin
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        resp_hit_d = 1'b0;
        resp_way_d = victim_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      victim_q   <= '0;
      resp_hit_q <= 1'b0;
      resp_way_q <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      victim_q   <= victim_d;
      resp_hit_q <= resp_hit_d;
      resp_way_q <= resp_way_d;
      if (state_q == S_FILL) begin
        valid_q[victim_q][idx_q] <= 1'b1;
        // WAY_W-bit add wraps because WAYS is a power of two.
        ptr_q[idx_q]             <= victim_q + 1'b1;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign tag_index  = idx_q;
  assign tag_we     = (state_q == S_FILL);
  assign tag_way    = (state_q == S_FILL) ? victim_q : '0;
  assign tag_wdata  = (state_q == S_FILL) ? tag_q : '0;
  assign mem_req    = (state_q == S_MISS);
  assign mem_addr   = (state_q == S_MISS) ? addr_q : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl: plays the tag array and the memory, drives
// directed and random requests and compares against a set-by-set cache model.
module tb_cache_lookup_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       resp_valid;
  logic       resp_hit;
  logic [1:0] resp_way;
  logic [1:0] tag_index;
  logic [7:0] tag_rd [4];
  logic       tag_we;
  logic [1:0] tag_way;
  logic [7:0] tag_wdata;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic       mem_ack;
  logic [2:0] dbg_state;

  int checks;
  int errors;

  cache_lookup_ctrl #(.WIDTH(8), .WAYS(4), .TOTAL_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .tag_index(tag_index), .tag_rd(tag_rd),
    .tag_we(tag_we), .tag_way(tag_way), .tag_wdata(tag_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tag array stand-in ----------------
  logic [7:0] arr [4][4];
  always_comb for (int w = 0; w < 4; w++) tag_rd[w] = arr[w][tag_index];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < 4; w++) for (int s = 0; s < 4; s++) arr[w][s] <= 8'h00;
    end else if (tag_we) begin
      arr[tag_way][tag_index] <= tag_wdata;
    end
  end

  // ---------------- reference cache model ----------------
  bit       m_valid [4][4];
  bit [7:0] m_tag   [4][4];
  int       m_ptr   [4];

  function automatic void model_reset();
    for (int w = 0; w < 4; w++) for (int s = 0; s < 4; s++) begin
      m_valid[w][s] = 0;
      m_tag[w][s]   = 8'h00;
    end
    for (int s = 0; s < 4; s++) m_ptr[s] = 0;
  endfunction

  // Returns hit/way for an access and updates the model as a fill would.
  function automatic void model_access(input logic [9:0] a, output bit hit, output int way);
    int set;
    bit [7:0] tag;
    set = int'(a % 4);
    tag = 8'(a / 4);
    hit = 0;
    way = -1;
    for (int w = 0; w < 4; w++)
      if (way < 0 && m_valid[w][set] && m_tag[w][set] == tag) begin
        hit = 1;
        way = w;
      end
    if (!hit) begin
      for (int w = 0; w < 4; w++)
        if (way < 0 && !m_valid[w][set]) way = w;
      if (way < 0) way = m_ptr[set];
      m_valid[way][set] = 1;
      m_tag[way][set]   = tag;
      m_ptr[set]        = (way + 1) % 4;
    end
  endfunction

  // ---------------- driver ----------------
  typedef struct {
    int         resp_cycle;
    logic       hit;
    logic [1:0] way;
    int         memreq_cycles;
    int         memreq_first;
    logic [9:0] mem_addr;
    int         we_count;
    int         we_cycle;
    logic [1:0] we_way;
    logic [7:0] we_data;
    logic [1:0] we_idx;
    int         ready_busy;
    bit         timeout;
  } obs_t;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Issues one request, answers mem_req after d extra cycles, records what
  // the DUT did; cycle k counts negedges after the accept edge.
  task automatic run_req(input logic [9:0] a, input int d, input bit hold, output obs_t o);
    int k;
    int cnt;
    int guard;
    o.resp_cycle = -1; o.hit = 1'bx; o.way = 2'bxx;
    o.memreq_cycles = 0; o.memreq_first = -1; o.mem_addr = '0;
    o.we_count = 0; o.we_cycle = -1; o.we_way = '0; o.we_data = '0; o.we_idx = '0;
    o.ready_busy = 0; o.timeout = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      o.timeout = 1;
      req_valid = 1'b0;
      return;
    end
    k = 0;
    cnt = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1 && !hold) req_valid = 1'b0;
      if (req_ready) o.ready_busy++;
      if (mem_req) begin
        cnt++;
        if (cnt == 1) o.memreq_first = k;
        o.mem_addr = mem_addr;
      end
      // Outside MISS mem_ack gets random noise, which must be ignored.
      mem_ack = mem_req ? (cnt > d) : ($urandom_range(0, 1) == 1);
      if (tag_we) begin
        o.we_count++;
        o.we_cycle = k;
        o.we_way   = tag_way;
        o.we_data  = tag_wdata;
        o.we_idx   = tag_index;
      end
      if (resp_valid) begin
        o.resp_cycle = k;
        o.hit        = resp_hit;
        o.way        = resp_way;
        break;
      end
    end
    o.memreq_cycles = cnt;
    if (o.resp_cycle < 0) o.timeout = 1;
    mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_way, tag_index, tag_we, mem_req} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b rv=%b hit=%b way=%0d idx=%0d we=%b mreq=%b exp rdy=1 rest 0",
               req_ready, resp_valid, resp_hit, resp_way, tag_index, tag_we, mem_req);
    end
    checks++;
    if ({tag_way, tag_wdata, mem_addr} !== 20'h0) begin
      errors++;
      $display("FAIL reset_data got tag_way=%0d wdata=%h mem_addr=%h exp 0", tag_way, tag_wdata, mem_addr);
    end
    apply_reset();
  endtask

  task automatic test_cold_miss();
    obs_t o; bit mh; int mw;
    run_req(10'h0E9, 3, 0, o);
    model_access(10'h0E9, mh, mw);
    checks++;
    if (o.timeout || o.hit !== 1'b0 || o.way !== 2'd0) begin
      errors++;
      $display("FAIL cold_resp got to=%0d hit=%b way=%0d exp hit=0 way=0", o.timeout, o.hit, o.way);
    end
    checks++;
    if (o.mem_addr !== 10'h0E9 || o.memreq_cycles != 4 || o.memreq_first != 2) begin
      errors++;
      $display("FAIL cold_mem got addr=%h cyc=%0d first=%0d exp addr=0e9 cyc=4 first=2",
               o.mem_addr, o.memreq_cycles, o.memreq_first);
    end
    checks++;
    if (o.we_count != 1 || o.we_way !== 2'd0 || o.we_idx !== 2'd1 || o.we_data !== 8'h3A || o.we_cycle != 6) begin
      errors++;
      $display("FAIL cold_write got n=%0d way=%0d idx=%0d data=%h cyc=%0d exp n=1 way=0 idx=1 data=3a cyc=6",
               o.we_count, o.we_way, o.we_idx, o.we_data, o.we_cycle);
    end
    checks++;
    if (o.resp_cycle != 7 || o.ready_busy != 0) begin
      errors++;
      $display("FAIL cold_latency got resp=%0d busy_ready=%0d exp resp=7 busy_ready=0", o.resp_cycle, o.ready_busy);
    end
  endtask

  task automatic test_rehit();
    obs_t o; bit mh; int mw;
    run_req(10'h0E9, 0, 0, o);
    model_access(10'h0E9, mh, mw);
    checks++;
    if (o.timeout || o.hit !== 1'b1 || o.way !== 2'd0 || o.resp_cycle != 2) begin
      errors++;
      $display("FAIL rehit_resp got hit=%b way=%0d resp=%0d exp hit=1 way=0 resp=2", o.hit, o.way, o.resp_cycle);
    end
    checks++;
    if (o.memreq_cycles != 0 || o.we_count != 0) begin
      errors++;
      $display("FAIL rehit_side got mem_req_cycles=%0d tag_we=%0d exp 0 0", o.memreq_cycles, o.we_count);
    end
  endtask

  task automatic test_set_wrap();
    obs_t o; bit mh; int mw;
    logic [7:0] tags [6];
    int exp_way [6];
    tags = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    exp_way = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      run_req({tags[i], 2'd2}, int'($urandom_range(0, 2)), 0, o);
      model_access({tags[i], 2'd2}, mh, mw);
      checks++;
      if (o.timeout || o.hit !== 1'b0 || o.way !== 2'(exp_way[i]) || o.we_way !== 2'(exp_way[i]) || o.we_data !== tags[i]) begin
        errors++;
        $display("FAIL set2_alloc[%0d] got hit=%b way=%0d we_way=%0d data=%h exp hit=0 way=%0d data=%h",
                 i, o.hit, o.way, o.we_way, o.we_data, exp_way[i], tags[i]);
      end
    end
    run_req({8'h12, 2'd2}, 0, 0, o);
    model_access({8'h12, 2'd2}, mh, mw);
    checks++;
    if (o.hit !== 1'b1 || o.way !== 2'd2 || o.we_count != 0 || o.resp_cycle != 2) begin
      errors++;
      $display("FAIL set2_hit got hit=%b way=%0d we=%0d resp=%0d exp hit=1 way=2 we=0 resp=2",
               o.hit, o.way, o.we_count, o.resp_cycle);
    end
  endtask

  task automatic test_zero_addr();
    obs_t o; bit mh; int mw;
    apply_reset();
    run_req(10'h000, 1, 0, o);
    model_access(10'h000, mh, mw);
    checks++;
    if (o.timeout || o.hit !== 1'b0 || o.memreq_cycles != 2 || o.mem_addr !== 10'h000 || o.resp_cycle != 5) begin
      errors++;
      $display("FAIL zero_addr got hit=%b mreq=%0d addr=%h resp=%0d exp hit=0 mreq=2 addr=000 resp=5",
               o.hit, o.memreq_cycles, o.mem_addr, o.resp_cycle);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; bit mh; int mw;
    run_req(10'h0F7, 0, 1, o);
    model_access(10'h0F7, mh, mw);
    checks++;
    if (o.memreq_cycles != 1 || o.we_cycle != 3 || o.resp_cycle != 4 || o.hit !== 1'b0 || o.way !== 2'd0) begin
      errors++;
      $display("FAIL ack_first got mreq=%0d we=%0d resp=%0d hit=%b way=%0d exp 1 3 4 0 0",
               o.memreq_cycles, o.we_cycle, o.resp_cycle, o.hit, o.way);
    end
    checks++;
    if (o.ready_busy != 0) begin
      errors++;
      $display("FAIL held_valid got ready_in_busy=%0d exp 0", o.ready_busy);
    end
    // req_valid is still high; the same address goes straight in from IDLE.
    run_req(10'h0F7, 0, 0, o);
    model_access(10'h0F7, mh, mw);
    checks++;
    if (o.timeout || o.hit !== 1'b1 || o.way !== 2'd0 || o.resp_cycle != 2) begin
      errors++;
      $display("FAIL held_rehit got hit=%b way=%0d resp=%0d exp 1 0 2", o.hit, o.way, o.resp_cycle);
    end
  endtask

  task automatic test_reset_mid_miss();
    obs_t o; bit mh; int mw;
    int guard;
    int bad;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 10'h2C3;
    mem_ack   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || tag_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || guard >= 20) begin
      errors++;
      $display("FAIL mid_reset got mreq=%b we=%b rv=%b rdy=%b wait=%0d exp 0 0 0 1 <20",
               mem_req, tag_we, resp_valid, req_ready, guard);
    end
    bad = 0;
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tag_we || resp_valid || mem_req) bad++;
    end
    mem_ack = 1'b0;
    model_reset();
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (tag_we || resp_valid || mem_req) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abandoned_fill got stray_cycles=%0d exp 0", bad);
    end
    run_req(10'h2C3, 1, 0, o);
    model_access(10'h2C3, mh, mw);
    checks++;
    if (o.timeout || o.hit !== 1'b0 || o.memreq_cycles != 2 || o.way !== 2'd0) begin
      errors++;
      $display("FAIL post_reset_miss got hit=%b mreq=%0d way=%0d exp 0 2 0", o.hit, o.memreq_cycles, o.way);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit mh;
    int mw;
    int d;
    logic [9:0] a;
    for (int n = 0; n < 80; n++) begin
      a = {8'(8'h20 + $urandom_range(0, 5)), 2'($urandom_range(0, 3))};
      d = int'($urandom_range(0, 3));
      run_req(a, d, 0, o);
      model_access(a, mh, mw);
      checks++;
      if (o.timeout || o.hit !== mh || o.way !== 2'(mw) || o.ready_busy != 0) begin
        errors++;
        $display("FAIL rand_resp[%0d] a=%h got to=%0d hit=%b way=%0d busy=%0d exp hit=%b way=%0d",
                 n, a, o.timeout, o.hit, o.way, o.ready_busy, mh, mw);
      end
      checks++;
      if (mh) begin
        if (o.resp_cycle != 2 || o.memreq_cycles != 0 || o.we_count != 0) begin
          errors++;
          $display("FAIL rand_hit[%0d] got resp=%0d mreq=%0d we=%0d exp 2 0 0",
                   n, o.resp_cycle, o.memreq_cycles, o.we_count);
        end
      end else begin
        if (o.resp_cycle != d + 4 || o.memreq_cycles != d + 1 || o.memreq_first != 2 || o.mem_addr !== a ||
            o.we_count != 1 || o.we_cycle != d + 3 || o.we_way !== 2'(mw) || o.we_data !== a[9:2] ||
            o.we_idx !== a[1:0]) begin
          errors++;
          $display("FAIL rand_miss[%0d] a=%h got resp=%0d mreq=%0d addr=%h we=%0d@%0d way=%0d data=%h exp resp=%0d mreq=%0d way=%0d",
                   n, a, o.resp_cycle, o.memreq_cycles, o.mem_addr, o.we_count, o.we_cycle, o.we_way,
                   o.we_data, d + 4, d + 1, mw);
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    model_reset();
    test_reset();
    test_cold_miss();
    test_rehit();
    test_set_wrap();
    test_zero_addr();
    test_back_to_back();
    test_reset_mid_miss();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
